// File: rtl/pc_gen.sv
//==============================================================================
// Module      : pc_gen
// Description : Program-counter generator with prioritised redirects, a
//               stall-time redirect buffer, fetch-address checking and a
//               saturating redirect counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_gen #(
    parameter int               WIDTH    = 32,
    parameter int unsigned      STEP     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_4180),
    parameter logic [WIDTH-1:0] IM_BASE  = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] IM_SIZE  = WIDTH'(32'h0000_1000),
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             pend_valid,
    output logic             adel,
    output logic [CNT_W-1:0] redir_cnt
);

    localparam logic [WIDTH-1:0] c_step    = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    // Window bounds carry one extra bit so IM_BASE+IM_SIZE cannot wrap.
    localparam logic [WIDTH:0]   c_win_lo  = {1'b0, IM_BASE};
    localparam logic [WIDTH:0]   c_win_hi  = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

    logic [WIDTH-1:0] r_pc;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_pend_target;
    logic [CNT_W-1:0] r_redir_cnt;

    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_pend_valid_next;
    logic [WIDTH-1:0] w_pend_target_next;
    logic             w_redir_req;
    logic [WIDTH-1:0] w_redir_target;
    logic             w_apply;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH:0]   w_pc_ext;
    logic             w_adel;

    assign w_pc_plus      = r_pc + c_step;
    assign w_redir_req    = jump | br_taken;
    assign w_redir_target = jump ? jump_target : br_target;
    assign w_cnt_inc      = (r_redir_cnt == c_cnt_max) ? r_redir_cnt
                                                       : r_redir_cnt + CNT_W'(1);

    assign w_pc_ext = {1'b0, r_pc};
    assign w_adel   = (r_pc[1:0] != 2'b00) | (w_pc_ext < c_win_lo) |
                      (w_pc_ext >= c_win_hi);

    always_comb begin
        w_pc_next          = w_pc_plus;
        w_pend_valid_next  = r_pend_valid;
        w_pend_target_next = r_pend_target;
        w_apply            = 1'b0;

        if (exc_req) begin
            w_pc_next         = EXC_VEC;
            w_pend_valid_next = 1'b0;
            w_apply           = 1'b1;
        end else if (eret) begin
            w_pc_next         = epc;
            w_pend_valid_next = 1'b0;
            w_apply           = 1'b1;
        end else if (stall) begin
            // Hold the PC; the newest redirect seen during the stall wins.
            w_pc_next = r_pc;
            if (w_redir_req) begin
                w_pend_target_next = w_redir_target;
                w_pend_valid_next  = 1'b1;
            end
        end else if (w_redir_req) begin
            w_pc_next         = w_redir_target;
            w_pend_valid_next = 1'b0;
            w_apply           = 1'b1;
        end else if (r_pend_valid) begin
            w_pc_next         = r_pend_target;
            w_pend_valid_next = 1'b0;
            w_apply           = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
            r_redir_cnt   <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_pend_valid  <= w_pend_valid_next;
            r_pend_target <= w_pend_target_next;
            if (w_apply) begin
                r_redir_cnt <= w_cnt_inc;
            end
        end
    end

    assign pc         = r_pc;
    assign pc_plus    = w_pc_plus;
    assign pend_valid = r_pend_valid;
    assign adel       = w_adel;
    assign redir_cnt  = r_redir_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
//==============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen: directed scenarios plus a
//               randomized run checked against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, jump, exc_req, eret;
    logic [31:0] br_target, jump_target, epc;
    logic [31:0] pc, pc_plus, pc2, pc_plus2;
    logic        pend_valid, adel, pend_valid2, adel2;
    logic [15:0] redir_cnt;
    logic [1:0]  redir_cnt2;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_pv;
    logic [31:0] m_pt;
    int          m_cnt;

    always #5 clk = ~clk;

    pc_gen u_dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_target(jump_target),
        .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc(pc), .pc_plus(pc_plus), .pend_valid(pend_valid),
        .adel(adel), .redir_cnt(redir_cnt)
    );

    pc_gen #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_target(jump_target),
        .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc(pc2), .pc_plus(pc_plus2), .pend_valid(pend_valid2),
        .adel(adel2), .redir_cnt(redir_cnt2)
    );

    function automatic logic exp_adel(input logic [31:0] a);
        longint v;
        v = longint'(a);
        return (a[1:0] != 2'b00) || (v < 64'h3000) || (v >= 64'h4000);
    endfunction

    // Applies the next-PC rules to the model using the inputs present at the edge.
    task automatic model_edge();
        if (reset) begin
            m_pc = 32'h3000; m_pv = 1'b0; m_pt = '0; m_cnt = 0;
        end else if (exc_req) begin
            m_pc = 32'h4180; m_pv = 1'b0; m_cnt++;
        end else if (eret) begin
            m_pc = epc; m_pv = 1'b0; m_cnt++;
        end else if (stall) begin
            if (jump || br_taken) begin
                m_pt = jump ? jump_target : br_target;
                m_pv = 1'b1;
            end
        end else if (jump || br_taken) begin
            m_pc = jump ? jump_target : br_target; m_pv = 1'b0; m_cnt++;
        end else if (m_pv) begin
            m_pc = m_pt; m_pv = 1'b0; m_cnt++;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic drive(input logic rs, input logic st, input logic br,
                         input logic [31:0] bt, input logic jp,
                         input logic [31:0] jt, input logic ex,
                         input logic er, input logic [31:0] ep);
        reset = rs; stall = st; br_taken = br; br_target = bt;
        jump = jp; jump_target = jt; exc_req = ex; eret = er; epc = ep;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (pc !== 32'h3000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
        total++; if (pc_plus !== 32'h3004) begin bad++; $display("FAIL reset_pc_plus got=%h exp=%h", pc_plus, 32'h3004); end
        total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", pend_valid); end
        total++; if (redir_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", redir_cnt); end
        total++; if (adel !== 1'b0) begin bad++; $display("FAIL reset_adel got=%b exp=0", adel); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp;
        for (int i = 1; i <= 3; i++) begin
            idle();
            exp = 32'h3000 + 32'(4 * i);
            total++; if (pc !== exp) begin bad++; $display("FAIL free_pc[%0d] got=%h exp=%h", i, pc, exp); end
            total++; if (pc_plus !== exp + 32'd4) begin bad++; $display("FAIL free_pc_plus[%0d] got=%h exp=%h", i, pc_plus, exp + 32'd4); end
            total++; if (adel !== 1'b0 || redir_cnt !== 16'd0) begin bad++; $display("FAIL free_flags[%0d] got adel=%b cnt=%0d exp adel=0 cnt=0", i, adel, redir_cnt); end
        end
    endtask

    task automatic test_stall_buffer();
        drive(0, 1, 1, 32'h3100, 0, 0, 0, 0, 0);
        total++; if (pc !== 32'h300C || pend_valid !== 1'b1) begin bad++; $display("FAIL stall1 got pc=%h pend=%b exp pc=300c pend=1", pc, pend_valid); end
        total++; if (pc_plus !== 32'h3010) begin bad++; $display("FAIL stall_pc_plus got=%h exp=3010", pc_plus); end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        total++; if (pc !== 32'h300C || pend_valid !== 1'b1 || redir_cnt !== 16'd0) begin bad++; $display("FAIL stall2 got pc=%h pend=%b cnt=%0d exp pc=300c pend=1 cnt=0", pc, pend_valid, redir_cnt); end
        idle();
        total++; if (pc !== 32'h3100 || pend_valid !== 1'b0 || redir_cnt !== 16'd1) begin bad++; $display("FAIL release got pc=%h pend=%b cnt=%0d exp pc=3100 pend=0 cnt=1", pc, pend_valid, redir_cnt); end
    endtask

    task automatic test_jump_over_branch();
        drive(0, 0, 1, 32'h3300, 1, 32'h3200, 0, 0, 0);
        total++; if (pc !== 32'h3200 || redir_cnt !== 16'd2) begin bad++; $display("FAIL jump_prio got pc=%h cnt=%0d exp pc=3200 cnt=2", pc, redir_cnt); end
    endtask

    task automatic test_exc_eret();
        drive(0, 1, 1, 32'h3500, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
        total++; if (pc !== 32'h4180 || pend_valid !== 1'b0 || redir_cnt !== 16'd3) begin bad++; $display("FAIL exc got pc=%h pend=%b cnt=%0d exp pc=4180 pend=0 cnt=3", pc, pend_valid, redir_cnt); end
        total++; if (adel !== 1'b1) begin bad++; $display("FAIL exc_adel got=%b exp=1", adel); end
        drive(0, 1, 0, 0, 0, 0, 0, 1, 32'h3014);
        total++; if (pc !== 32'h3014 || redir_cnt !== 16'd4) begin bad++; $display("FAIL eret got pc=%h cnt=%0d exp pc=3014 cnt=4", pc, redir_cnt); end
        drive(0, 0, 0, 0, 1, 32'h3800, 1, 1, 32'h3040);
        total++; if (pc !== 32'h4180 || redir_cnt !== 16'd5) begin bad++; $display("FAIL exc_over_eret got pc=%h cnt=%0d exp pc=4180 cnt=5", pc, redir_cnt); end
    endtask

    task automatic test_adel();
        drive(0, 0, 0, 0, 1, 32'h3002, 0, 0, 0);
        total++; if (pc !== 32'h3002 || adel !== 1'b1) begin bad++; $display("FAIL adel_misalign got pc=%h adel=%b exp pc=3002 adel=1", pc, adel); end
        drive(0, 0, 0, 0, 1, 32'h4000, 0, 0, 0);
        total++; if (adel !== 1'b1) begin bad++; $display("FAIL adel_window_end got=%b exp=1", adel); end
        drive(0, 0, 0, 0, 1, 32'h3FFC, 0, 0, 0);
        total++; if (adel !== 1'b0) begin bad++; $display("FAIL adel_last_word got=%b exp=0", adel); end
        drive(0, 0, 0, 0, 1, 32'h2FFC, 0, 0, 0);
        total++; if (adel !== 1'b1) begin bad++; $display("FAIL adel_below got=%b exp=1", adel); end
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        total++; if (pc_plus !== 32'h0) begin bad++; $display("FAIL wrap_pc_plus got=%h exp=0", pc_plus); end
        idle();
        total++; if (pc !== 32'h0 || adel !== 1'b1) begin bad++; $display("FAIL wrap got pc=%h adel=%b exp pc=0 adel=1", pc, adel); end
    endtask

    task automatic test_reset_mid_pending();
        drive(0, 1, 0, 0, 1, 32'h3600, 0, 0, 0);
        total++; if (pend_valid !== 1'b1) begin bad++; $display("FAIL pend_before_reset got=%b exp=1", pend_valid); end
        drive(1, 1, 1, 32'h3700, 0, 0, 1, 0, 0);
        total++; if (pc !== 32'h3000 || pend_valid !== 1'b0 || redir_cnt !== 16'd0) begin bad++; $display("FAIL reset_mid got pc=%h pend=%b cnt=%0d exp pc=3000 pend=0 cnt=0", pc, pend_valid, redir_cnt); end
        idle();
        total++; if (pc !== 32'h3004) begin bad++; $display("FAIL after_reset got pc=%h exp=3004", pc); end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 0, 1, 32'h3000 + 32'(16 * i), 0, 0, 0);
            total++; if (redir_cnt2 !== 2'((i > 3) ? 3 : i)) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, redir_cnt2, (i > 3) ? 3 : i); end
        end
        total++; if (redir_cnt !== 16'd5) begin bad++; $display("FAIL wide_cnt got=%0d exp=5", redir_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] t1, t2, e;
        int          sat;
        for (int n = 0; n < 400; n++) begin
            t1 = ($urandom_range(0, 3) == 0) ? $urandom() : 32'h3000 + 32'($urandom_range(0, 1023) << 2);
            t2 = ($urandom_range(0, 3) == 0) ? $urandom() : 32'h3000 + 32'($urandom_range(0, 1023) << 2);
            e  = 32'h3000 + 32'($urandom_range(0, 1023) << 2);
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 2, t1, $urandom_range(0, 19) < 3, t2,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, e);
            sat = (m_cnt > 3) ? 3 : m_cnt;
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", n, pc, m_pc); end
            total++; if (pc_plus !== m_pc + 32'd4) begin bad++; $display("FAIL rnd_pc_plus[%0d] got=%h exp=%h", n, pc_plus, m_pc + 32'd4); end
            total++; if (pend_valid !== m_pv) begin bad++; $display("FAIL rnd_pend[%0d] got=%b exp=%b", n, pend_valid, m_pv); end
            total++; if (adel !== exp_adel(m_pc)) begin bad++; $display("FAIL rnd_adel[%0d] got=%b exp=%b", n, adel, exp_adel(m_pc)); end
            total++; if (redir_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", n, redir_cnt, m_cnt); end
            total++; if (redir_cnt2 !== 2'(sat) || pc2 !== m_pc) begin bad++; $display("FAIL rnd_sat[%0d] got cnt=%0d pc=%h exp cnt=%0d pc=%h", n, redir_cnt2, pc2, sat, m_pc); end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
        exc_req = 1'b0; eret = 1'b0; br_target = '0; jump_target = '0; epc = '0;
        m_pc = '0; m_pv = 1'b0; m_pt = '0; m_cnt = 0;
        test_reset();
        test_free_run();
        test_stall_buffer();
        test_jump_over_branch();
        test_exc_eret();
        test_adel();
        test_reset_mid_pending();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
